// File: rtl/fifo_rd_pack.sv
// fifo_rd_pack: pops DATA_W-bit words from a first-word-fall-through FIFO
// and packs PACK_N of them into one output word. The first popped word
// lands in the LSBs. A flush request emits a partially filled word, and
// the unfilled slots read as zero.
// Optional feature: define FIFO_RD_PARITY_EN to drive out_par with the
// even parity of out_data. Without it, out_par is tied to 0.
module fifo_rd_pack #(
    parameter int DATA_W = 4,
    parameter int PACK_N = 2
) (
    input  logic                         rd_clk,
    input  logic                         rd_rst,
    input  logic                         empty,
    input  logic [DATA_W-1:0]            rd_data,
    output logic                         rd_en,
    input  logic                         flush,
    output logic [DATA_W*PACK_N-1:0]     out_data,
    output logic [$clog2(PACK_N+1)-1:0]  out_len,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_par
);

    localparam int CNT_W = $clog2(PACK_N+1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PACK_N-1);

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] OUT  = 1'b1;

    logic [0:0]               state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [DATA_W*PACK_N-1:0] data_q;
    logic [DATA_W*PACK_N-1:0] data_d;
    logic                     flush_go;
    logic                     pop;
    logic                     xfer;

    // A flush with at least one collected word wins over a pop in the same cycle.
    assign flush_go = (state_q == FILL) && flush && (cnt_q != '0);
    assign pop      = !rd_rst && (state_q == FILL) && !empty && !flush_go;
    assign xfer     = (state_q == OUT) && out_ready;

    assign rd_en     = pop;
    assign out_valid = (state_q == OUT);
    // cnt_q already holds the word count when the block is in OUT.
    assign out_len   = (state_q == OUT) ? cnt_q : '0;
    assign out_data  = data_q;

    // Next slot contents: write the popped word into slot cnt, or clear all slots on transfer.
    always_comb begin
        data_d = data_q;
        if (pop) begin
            for (int unsigned k = 0; k < PACK_N; k++) begin
                if (cnt_q == CNT_W'(k)) begin
                    data_d[k*DATA_W +: DATA_W] = rd_data;
                end
            end
        end
        if (xfer) begin
            data_d = '0;
        end
    end

    // FILL/OUT sequencing, word count and slot storage.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            data_q <= data_d;
            case (state_q)
                FILL: begin
                    if (flush_go) begin
                        state_q <= OUT;
                    end else if (pop) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST) begin
                            state_q <= OUT;
                        end
                    end
                end
                default: begin
                    if (out_ready) begin
                        state_q <= FILL;
                        cnt_q   <= '0;
                    end
                end
            endcase
        end
    end

`ifdef FIFO_RD_PARITY_EN
    logic par_q;

    // Parity is registered from the same next-state value as data_q, so it tracks out_data exactly.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= ^data_d;
        end
    end

    assign out_par = par_q;
`else
    assign out_par = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_pack.sv
// Directed testbench for fifo_rd_pack (DATA_W=4, PACK_N=2). A queue models
// the FIFO. Each expected packed word is pushed to a scoreboard when its
// stimulus is queued. The scoreboard entry is compared while out_valid is
// high and popped when the word is transferred.
module tb_fifo_rd_pack;

    localparam int DATA_W = 4;
    localparam int PACK_N = 2;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] len;
    } exp_t;

    logic       clk = 1'b0;
    logic       rd_rst;
    logic       empty;
    logic [3:0] rd_data;
    logic       rd_en;
    logic       flush;
    logic [7:0] out_data;
    logic [1:0] out_len;
    logic       out_valid;
    logic       out_ready;
    logic       out_par;

    logic [3:0] fifo_q[$];
    exp_t       sb[$];

    int n_assert = 0;
    int n_fail   = 0;
    int n_xfer   = 0;

    // reference state for the cycle-level check
    logic       m_out = 1'b0;
    int         m_cnt = 0;

    fifo_rd_pack #(.DATA_W(DATA_W), .PACK_N(PACK_N)) dut (
        .rd_clk    (clk),
        .rd_rst    (rd_rst),
        .empty     (empty),
        .rd_data   (rd_data),
        .rd_en     (rd_en),
        .flush     (flush),
        .out_data  (out_data),
        .out_len   (out_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_par   (out_par)
    );

    always #5 clk = ~clk;

    function automatic logic exp_par(input logic [7:0] d);
`ifdef FIFO_RD_PARITY_EN
        return ^d;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fifo_update();
        empty   = (fifo_q.size() == 0);
        rd_data = empty ? 4'h0 : fifo_q[0];
    endtask

    task automatic push_fifo(input logic [3:0] w);
        fifo_q.push_back(w);
        fifo_update();
    endtask

    task automatic push_exp(input logic [7:0] d, input logic [1:0] len);
        exp_t e;
        e.data = d;
        e.len  = len;
        sb.push_back(e);
    endtask

    // One clock cycle: check at the falling edge, then advance the model and the FIFO after the rising edge.
    task automatic tick();
        logic exp_rd;
        logic popped;
        exp_t e;
        @(negedge clk);
        exp_rd = !rd_rst && !m_out && !empty && !(flush && m_cnt != 0);
        chk("rd_en", 32'(rd_en), 32'(exp_rd));
        chk("out_valid", 32'(out_valid), 32'(m_out));
        if (m_out) begin
            n_assert++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_empty: observed out_valid=1 expected no pending word");
            end
            if (sb.size() != 0) begin
                e = sb[0];
                chk("out_data", 32'(out_data), 32'(e.data));
                chk("out_len",  32'(out_len),  32'(e.len));
                chk("out_par",  32'(out_par),  32'(exp_par(e.data)));
            end
        end
        popped = (rd_en === 1'b1);
        if (rd_rst) begin
            m_out = 1'b0;
            m_cnt = 0;
            sb.delete();
        end else if (m_out) begin
            if (out_ready) begin
                if (sb.size() != 0) void'(sb.pop_front());
                m_out = 1'b0;
                m_cnt = 0;
                n_xfer++;
            end
        end else if (flush && m_cnt != 0) begin
            m_out = 1'b1;
        end else if (exp_rd) begin
            m_cnt++;
            if (m_cnt == PACK_N) m_out = 1'b1;
        end
        @(posedge clk);
        #1;
        if (popped && fifo_q.size() != 0) void'(fifo_q.pop_front());
        fifo_update();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int x0;
        rd_rst    = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        fifo_update();

        // reset with a non-empty FIFO: no pops while rd_rst=1
        push_fifo(4'h3);
        push_fifo(4'hA);
        run(3);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data",  32'(out_data),  32'h0);
        chk("rst_out_len",   32'(out_len),   32'h0);
        chk("rst_out_par",   32'(out_par),   32'h0);

        // 0x3,0xA packed into 0xA3 and accepted at once
        rd_rst    = 1'b0;
        out_ready = 1'b1;
        push_exp(8'hA3, 2'd2);
        run(4);

        // 0x5C held under backpressure; flush in OUT is ignored; FIFO not popped in OUT
        out_ready = 1'b0;
        push_fifo(4'hC);
        push_fifo(4'h5);
        push_exp(8'h5C, 2'd2);
        run(2);
        push_fifo(4'h1);
        push_fifo(4'h2);
        push_exp(8'h21, 2'd2);
        flush = 1'b1;
        run(5);
        flush     = 1'b0;
        out_ready = 1'b1;
        x0 = n_xfer;
        run(5);
        chk("single_xfer_5c_21", 32'(n_xfer - x0), 32'd2);

        // partial word flushed with the FIFO holding another word: no pop in the flush cycle
        push_fifo(4'h7);
        tick();
        push_fifo(4'h9);
        push_exp(8'h07, 2'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        push_fifo(4'h4);
        push_exp(8'h49, 2'd2);
        run(5);

        // flush with cnt=0 and empty FIFO: nothing happens
        flush = 1'b1;
        run(3);
        flush = 1'b0;

        // reset while a word is presented: word discarded, later 0x1,0x2 gives 0x21
        out_ready = 1'b0;
        push_fifo(4'h6);
        push_fifo(4'h8);
        push_exp(8'h86, 2'd2);
        run(4);
        rd_rst = 1'b1;
        x0 = n_xfer;
        tick();
        rd_rst = 1'b0;
        tick();
        chk("rst_no_xfer", 32'(n_xfer - x0), 32'd0);
        push_fifo(4'h1);
        push_fifo(4'h2);
        push_exp(8'h21, 2'd2);
        out_ready = 1'b1;
        run(4);

        // reset mid-fill discards the partial word
        push_fifo(4'h3);
        tick();
        rd_rst = 1'b1;
        tick();
        rd_rst = 1'b0;
        push_fifo(4'h4);
        push_fifo(4'h5);
        push_exp(8'h54, 2'd2);
        run(4);

        // parity row: word 0x0B
        push_fifo(4'hB);
        push_fifo(4'h0);
        push_exp(8'h0B, 2'd2);
        run(4);

        // back-to-back words at one per PACK_N+1 cycles
        for (int i = 1; i <= 6; i++) push_fifo(4'(i));
        push_exp(8'h21, 2'd2);
        push_exp(8'h43, 2'd2);
        push_exp(8'h65, 2'd2);
        x0 = n_xfer;
        run(9);
        chk("throughput_xfers", 32'(n_xfer - x0), 32'd3);

        // bounded drain of anything left over
        for (int i = 0; i < 50 && (sb.size() != 0 || fifo_q.size() != 0); i++) tick();
        chk("drain_sb",   32'(sb.size()),     32'd0);
        chk("drain_fifo", 32'(fifo_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rd_pack.md
FIFO_RD_PACK -- requirements
Module: fifo_rd_pack

Interface
REQ-001 Parameter DATA_W, default 4: FIFO word width in bits.
REQ-002 Parameter PACK_N, default 2: FIFO words packed per output word; legal range 2..8.
REQ-003 rd_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rd_rst  input  1  reset, synchronous and active-high.
REQ-005 empty  input  1  FIFO empty flag, synchronous to rd_clk.
REQ-006 rd_data  input  DATA_W  FIFO head word; valid whenever empty=0 (first-word-fall-through).
REQ-007 rd_en  output  1  FIFO pop; the head word is consumed on each rising edge where rd_en=1.
REQ-008 flush  input  1  request to emit a partially filled word.
REQ-009 out_data  output  DATA_W*PACK_N  packed word; FIFO word k sits at bits [k*DATA_W +: DATA_W], with the first-popped word in the LSBs.
REQ-010 out_len  output  clog2(PACK_N+1)  number of valid FIFO words in out_data (1..PACK_N).
REQ-011 out_valid  output  1  out_data, out_len and out_par are valid.
REQ-012 out_ready  input  1  downstream accept; a transfer occurs on a cycle where out_valid=1 and out_ready=1.
REQ-013 out_par  output  1  parity of out_data (see Configuration).

Function
REQ-014 The block SHALL be a two-state machine: FILL (collect words) and OUT (present a word).
REQ-015 In FILL, rd_en SHALL equal !empty && !(flush && cnt!=0); it SHALL be combinational, with no latency from empty.
REQ-016 On each pop, rd_data SHALL be registered into slot cnt, and the internal count cnt SHALL increment by 1.
REQ-017 A pop with cnt==PACK_N-1 SHALL move to OUT on the next cycle, with out_len=PACK_N and out_valid=1.
REQ-018 In FILL, flush=1 with cnt!=0 SHALL move to OUT with out_len=cnt, and unfilled slots SHALL read as zero. No pop SHALL occur in that cycle.
REQ-019 flush with cnt==0, or flush in OUT, SHALL be ignored.
REQ-020 In OUT, rd_en SHALL be 0. out_data, out_len and out_par SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 On a transfer, the block SHALL return to FILL next cycle, with cnt=0, all slots cleared and out_valid=0.
REQ-022 Peak throughput SHALL be one packed word per PACK_N+1 cycles; there is no pop in the cycle that a word is accepted.
REQ-023 out_valid SHALL never deassert without a transfer, except on reset.
REQ-024 empty toggling mid-word SHALL only stall filling; cnt and the slot contents SHALL be preserved.

Reset
REQ-025 While rd_rst=1 at a clock edge, the block SHALL be in FILL with cnt=0, slots=0, out_valid=0, out_data=0, out_len=0, out_par=0.
REQ-026 rd_en SHALL be 0 during any cycle in which rd_rst=1.
REQ-027 Reset asserted during OUT or mid-fill SHALL discard the pending word; no transfer occurs and no word is re-emitted.

Configuration
REQ-028 The macro is FIFO_RD_PARITY_EN.
REQ-029 With FIFO_RD_PARITY_EN defined, out_par SHALL be XOR-reduce of out_data (even parity over all bits, zero pad included). It SHALL be registered alongside out_data.
REQ-030 Without FIFO_RD_PARITY_EN, out_par SHALL be tied to 0 and no parity logic SHALL be built.

Verification (DATA_W=4, PACK_N=2)
REQ-031 Rows are stimulus -> required response:
- FIFO holds 0x3,0xA; out_ready=1 -> two rd_en pulses, then out_data=0xA3, out_len=2, out_valid for 1 cycle.
- Word 0x5C presented; out_ready=0 for 5 cycles, then 1 -> rd_en stays 0, out_data holds 0x5C, a single transfer occurs.
- One word 0x7 popped, FIFO then empty, flush=1 -> out_data=0x07, out_len=1, and no rd_en in the flush cycle.
- flush=1 with cnt=0 and FIFO empty -> no out_valid and no state change.
- rd_rst=1 while out_valid=1 -> next cycle out_valid=0 and cnt=0; a later 0x1,0x2 yields 0x21.
- FIFO_RD_PARITY_EN defined, word 0x0B -> out_par=1; undefined -> out_par=0.
